// File: rtl/syscall_console_unit.sv
// rtl/syscall_console_unit.sv - MIPS syscall service unit: print_int/print_string/exit, TX byte FIFO, watchdog
module syscall_console_unit #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DM_AW       = 30,
  parameter int MAX_STR     = 256,
  parameter int WDOG_CYCLES = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall_i,
  input  logic [31:0]      v0_i,
  input  logic [31:0]      a0_i,
  output logic             stall_o,
  output logic             dm_req_o,
  output logic [DM_AW-1:0] dm_addr_o,
  input  logic [31:0]      dm_rdata_i,
  output logic             tx_valid_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i,
  output logic             halt_o,
  output logic             err_o,
  output logic             wdog_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(MAX_STR + 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_STR  = CW'(MAX_STR - 1);
  localparam logic [31:0]   WDOG_LIM  = 32'(WDOG_CYCLES);
  localparam logic [31:0]   V0_INT    = 32'd1;
  localparam logic [31:0]   V0_STR    = 32'd4;
  localparam logic [31:0]   V0_EXIT   = 32'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_INT_CONV, S_INT_EMIT, S_STR_REQ, S_STR_WAIT, S_STR_EMIT, S_EXIT_DRAIN, S_HALTED
  } state_t;

  state_t          state_q, state_d;
  logic            neg_q, neg_d;
  logic            sgn_q, sgn_d;
  logic            lead_q, lead_d;
  logic [31:0]     bin_q, bin_d;
  logic [39:0]     bcd_q, bcd_d;
  logic [39:0]     bcd_adj;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     word_q, word_d;
  logic [CW-1:0]   scnt_q, scnt_d;
  logic            halt_q, halt_d;
  logic            err_q, err_d;
  logic            wdog_q, wdog_d;
  logic [31:0]     wcnt_q, wcnt_d;

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]     fcnt_q, fcnt_d;

  logic            accept, fifo_empty, fifo_full, pop, can_push, push;
  logic [7:0]      push_data;
  logic [3:0]      cur_dig;
  logic [7:0]      cur_byte;
  logic [31:0]     mag;

  assign accept     = syscall_i & ~halt_q & ~wdog_q;
  assign stall_o    = (state_q != S_IDLE) | accept;
  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == FULL_CNT);
  assign pop        = ~fifo_empty & tx_ready_i;
  assign can_push   = ~fifo_full | pop;
  assign tx_valid_o = ~fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'h00 : fifo_q[rd_q];
  assign dm_req_o   = (state_q == S_STR_REQ);
  assign dm_addr_o  = dm_req_o ? addr_q[DM_AW+1:2] : '0;
  assign halt_o     = halt_q;
  assign err_o      = err_q;
  assign wdog_o     = wdog_q;
  assign cur_dig    = bcd_q[{idx_q, 2'b00} +: 4];
  assign cur_byte   = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign mag        = a0_i[31] ? (~a0_i + 32'd1) : a0_i;

  // Double-dabble add-3 correction applied to every BCD digit before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath: call dispatch, integer conversion/emit, string walk, exit drain
  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    sgn_d     = sgn_q;
    lead_d    = lead_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    word_d    = word_q;
    scnt_d    = scnt_q;
    halt_d    = halt_q;
    err_d     = 1'b0;
    push      = 1'b0;
    push_data = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (v0_i)
            V0_INT: begin
              neg_d   = a0_i[31];
              bin_d   = mag;
              bcd_d   = '0;
              cnt_d   = '0;
              state_d = S_INT_CONV;
            end
            V0_STR: begin
              addr_d  = a0_i;
              scnt_d  = '0;
              state_d = S_STR_REQ;
            end
            V0_EXIT: state_d = S_EXIT_DRAIN;
            default: err_d = 1'b1;
          endcase
        end
      end
      S_INT_CONV: begin
        bcd_d = {bcd_adj[38:0], bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          idx_d   = 4'd9;
          sgn_d   = neg_q;
          lead_d  = 1'b0;
          state_d = S_INT_EMIT;
        end
      end
      S_INT_EMIT: begin
        if (sgn_q) begin
          if (can_push) begin
            push      = 1'b1;
            push_data = 8'h2D;
            sgn_d     = 1'b0;
          end
        end else if (!lead_q && cur_dig == 4'd0 && idx_q != 4'd0) begin
          idx_d = idx_q - 4'd1;
        end else if (can_push) begin
          push      = 1'b1;
          push_data = {4'h3, cur_dig};
          lead_d    = 1'b1;
          if (idx_q == 4'd0) state_d = S_IDLE;
          else               idx_d   = idx_q - 4'd1;
        end
      end
      S_STR_REQ:  state_d = S_STR_WAIT;
      S_STR_WAIT: begin
        word_d  = dm_rdata_i;
        state_d = S_STR_EMIT;
      end
      S_STR_EMIT: begin
        if (cur_byte == 8'h00) begin
          state_d = S_IDLE;
        end else if (can_push) begin
          push      = 1'b1;
          push_data = cur_byte;
          addr_d    = addr_q + 32'd1;
          scnt_d    = scnt_q + 1'b1;
          if (scnt_q == LAST_STR) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (addr_q[1:0] == 2'd3) begin
            state_d = S_STR_REQ;
          end
        end
      end
      S_EXIT_DRAIN: begin
        if (fifo_empty) begin
          halt_d  = 1'b1;
          state_d = S_HALTED;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state and call datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      lead_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      scnt_q  <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      lead_q  <= lead_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      scnt_q  <= scnt_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // FIFO pointer and occupancy update; push+pop together leaves the count unchanged
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!push && pop) fcnt_d = fcnt_q - 1'b1;
  end

  // TX FIFO storage and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) fifo_q[wr_q] <= push_data;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Watchdog: counts while running, freezes once tripped or after exit
  always_comb begin
    wcnt_d = wcnt_q;
    wdog_d = wdog_q;
    if (WDOG_CYCLES != 0 && !wdog_q && !halt_q) begin
      wcnt_d = wcnt_q + 32'd1;
      if (wcnt_d == WDOG_LIM) wdog_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

endmodule

// File: tb/tb_syscall_console_unit.sv
// tb/tb_syscall_console_unit.sv - scoreboard bench for syscall_console_unit
module tb_syscall_console_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        syscall = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        stall_o, dm_req_o, tx_valid_o, halt_o, err_o, wdog_o;
  logic [29:0] dm_addr_o;
  logic [31:0] dm_rdata = '0;
  logic [7:0]  tx_data_o;
  logic        tx_ready = 1'b0;

  logic        rst_w = 1'b0;
  logic        syscall_w = 1'b0;
  logic        stall_w, dm_req_w, tx_valid_w, halt_w, err_w, wdog_w;
  logic [29:0] dm_addr_w;
  logic [7:0]  tx_data_w;

  logic [31:0] mem [0:127];
  logic [7:0]  exp_q [$];
  logic [29:0] req_log [$];
  logic [7:0]  exp_b;
  int          checks = 0;
  int          errors = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  syscall_console_unit #(.FIFO_DEPTH(4), .DM_AW(30), .MAX_STR(256), .WDOG_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .syscall_i(syscall), .v0_i(v0), .a0_i(a0),
    .stall_o(stall_o), .dm_req_o(dm_req_o), .dm_addr_o(dm_addr_o), .dm_rdata_i(dm_rdata),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready),
    .halt_o(halt_o), .err_o(err_o), .wdog_o(wdog_o)
  );

  syscall_console_unit #(.FIFO_DEPTH(4), .DM_AW(30), .MAX_STR(256), .WDOG_CYCLES(50)) dut_w (
    .clk(clk), .rst(rst_w), .syscall_i(syscall_w), .v0_i(v0), .a0_i(a0),
    .stall_o(stall_w), .dm_req_o(dm_req_w), .dm_addr_o(dm_addr_w), .dm_rdata_i(dm_rdata),
    .tx_valid_o(tx_valid_w), .tx_data_o(tx_data_w), .tx_ready_i(1'b1),
    .halt_o(halt_w), .err_o(err_w), .wdog_o(wdog_w)
  );

  // Data memory: read data valid the cycle after the request
  always @(posedge clk) if (dm_req_o) dm_rdata <= mem[dm_addr_o[6:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte, logs err pulses and reads
  always @(negedge clk) begin
    if (rst && tx_valid_o && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %02h, expected no byte", tx_data_o);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_byte", 64'(tx_data_o), 64'(exp_b));
      end
    end
    if (err_o) err_cnt++;
    if (dm_req_o) req_log.push_back(dm_addr_o);
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic call(input logic [31:0] v, input logic [31:0] a);
    @(posedge clk); #1;
    v0 = v; a0 = a; syscall = 1'b1;
    @(negedge clk);
    chk("stall_req", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    syscall = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (stall_o && cyc < budget) begin
      cyc++;
      @(negedge clk);
    end
    chk("idle_timeout", 64'(stall_o), 64'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc, e0, r0;
    bit halt_early, halt_seen;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem[4] = 32'h6C6C6548;
    mem[5] = 32'h0000216F;
    for (int k = 0; k < 320; k++) mem[32 + k/4][8*(k%4) +: 8] = 8'h41 + 8'(k % 26);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_dm_req", 64'(dm_req_o), 64'd0);
    chk("rst_dm_addr", 64'(dm_addr_o), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    chk("rst_tx_data", 64'(tx_data_o), 64'd0);
    chk("rst_halt", 64'(halt_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_wdog", 64'(wdog_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tx_ready = 1'b1;

    // print_int 0 and -2^31: 32 conversion cycles + 10 digit slots (+1 sign)
    push_str("0");
    call(32'd1, 32'd0);
    wait_idle(200, cyc);
    chk("int0_cycles", 64'(cyc), 64'd42);
    wait_drain(100);
    push_str("-2147483648");
    call(32'd1, 32'h80000000);
    wait_idle(200, cyc);
    chk("intmin_cycles", 64'(cyc), 64'd43);
    wait_drain(100);

    // print_string from byte address 0x13 spanning words 4 and 5
    r0 = req_log.size();
    push_str("lo!");
    call(32'd4, 32'h13);
    wait_idle(200, cyc);
    wait_drain(100);
    repeat (3) @(negedge clk);
    chk("str_req_count", 64'(req_log.size() - r0), 64'd2);
    if (req_log.size() - r0 == 2) begin
      chk("str_req_addr0", 64'(req_log[r0]), 64'd4);
      chk("str_req_addr1", 64'(req_log[r0+1]), 64'd5);
    end

    // FIFO full with sink stalled, then released
    tx_ready = 1'b0;
    push_str("123456");
    call(32'd1, 32'd123456);
    repeat (60) @(negedge clk);
    chk("full_stall", 64'(stall_o), 64'd1);
    chk("full_valid", 64'(tx_valid_o), 64'd1);
    chk("full_head", 64'(tx_data_o), 64'h31);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle(200, cyc);
    wait_drain(100);

    // Invalid code: one err pulse, nothing emitted
    e0 = err_cnt;
    call(32'd7, 32'd0);
    wait_idle(10, cyc);
    chk("inv_cycles", 64'(cyc), 64'd0);
    repeat (3) @(negedge clk);
    chk("inv_err_pulses", 64'(err_cnt - e0), 64'd1);
    chk("inv_tx_valid", 64'(tx_valid_o), 64'd0);

    // Unterminated string truncated at 256 bytes
    for (int k = 0; k < 256; k++) exp_q.push_back(8'h41 + 8'(k % 26));
    e0 = err_cnt;
    call(32'd4, 32'd128);
    wait_idle(2000, cyc);
    wait_drain(100);
    repeat (3) @(negedge clk);
    chk("trunc_err_pulses", 64'(err_cnt - e0), 64'd1);
    chk("trunc_tx_valid", 64'(tx_valid_o), 64'd0);

    // Asynchronous reset in the middle of a string
    tx_ready = 1'b0;
    call(32'd4, 32'd128);
    repeat (20) @(negedge clk);
    chk("mid_stall", 64'(stall_o), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(stall_o), 64'd0);
    chk("mid_rst_valid", 64'(tx_valid_o), 64'd0);
    chk("mid_rst_dm_req", 64'(dm_req_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", 64'(tx_valid_o), 64'd0);
    chk("post_rst_stall", 64'(stall_o), 64'd0);

    // Exit with queued bytes and a toggling sink
    tx_ready = 1'b0;
    push_str("9876");
    call(32'd1, 32'd9876);
    wait_idle(200, cyc);
    call(32'd10, 32'd0);
    halt_early = 1'b0;
    halt_seen  = 1'b0;
    for (int i = 0; i < 200 && !halt_seen; i++) begin
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
      @(negedge clk);
      if (halt_o && (tx_valid_o || exp_q.size() != 0)) halt_early = 1'b1;
      if (halt_o) halt_seen = 1'b1;
    end
    chk("exit_halt_seen", 64'(halt_seen), 64'd1);
    chk("exit_halt_early", 64'(halt_early), 64'd0);
    chk("exit_drained", 64'(exp_q.size()), 64'd0);
    chk("exit_stall", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    v0 = 32'd1; a0 = 32'd5; syscall = 1'b1;
    repeat (50) @(negedge clk);
    chk("halted_stall", 64'(stall_o), 64'd1);
    chk("halted_halt", 64'(halt_o), 64'd1);
    chk("halted_tx", 64'(tx_valid_o), 64'd0);
    @(posedge clk); #1;
    syscall = 1'b0;

    // Watchdog on the second instance
    rst_w = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 49) chk("wdog_before", 64'(wdog_w), 64'd0);
      if (i == 50) chk("wdog_at_50", 64'(wdog_w), 64'd1);
    end
    @(posedge clk); #1;
    v0 = 32'd1; a0 = 32'd5; syscall_w = 1'b1;
    @(negedge clk);
    chk("wdog_no_stall", 64'(stall_w), 64'd0);
    repeat (50) @(negedge clk);
    chk("wdog_no_tx", 64'(tx_valid_w), 64'd0);
    chk("wdog_tx_data", 64'(tx_data_w), 64'd0);
    chk("wdog_sticky", 64'(wdog_w), 64'd1);
    chk("wdog_halt", 64'(halt_w), 64'd0);
    chk("wdog_err", 64'(err_w), 64'd0);
    chk("wdog_dm", 64'({dm_req_w, dm_addr_w}), 64'd0);
    chk("main_wdog_off", 64'(wdog_o), 64'd0);
    @(posedge clk); #1;
    syscall_w = 1'b0;

    chk("final_scoreboard", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
